// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: operation codes and FSM states.
package usr_pkg;

  typedef enum logic [2:0] {
    OP_HOLD  = 3'd0,
    OP_LOAD  = 3'd1,
    OP_SHL   = 3'd2,
    OP_SHR   = 3'd3,
    OP_ROL   = 3'd4,
    OP_ROR   = 3'd5,
    OP_ASR   = 3'd6,
    OP_CLEAR = 3'd7
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  function automatic logic is_shift_op(op_e o);
    return (o != OP_HOLD) && (o != OP_LOAD) && (o != OP_CLEAR);
  endfunction

endpackage

// File: rtl/usr_step.sv
// Combinational single-bit shift/rotate step; non-shift ops pass q through.
module usr_step
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  op_e              op,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q_next,
  output logic             bit_out
);

  always_comb begin
    q_next  = q;
    bit_out = 1'b0;
    case (op)
      OP_SHL: begin
        q_next  = {q[WIDTH-2:0], ser_in};
        bit_out = q[WIDTH-1];
      end
      OP_SHR: begin
        q_next  = {ser_in, q[WIDTH-1:1]};
        bit_out = q[0];
      end
      OP_ROL: begin
        q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
        bit_out = q[WIDTH-1];
      end
      OP_ROR: begin
        q_next  = {q[0], q[WIDTH-1:1]};
        bit_out = q[0];
      end
      OP_ASR: begin
        q_next  = {q[WIDTH-1], q[WIDTH-1:1]};
        bit_out = q[0];
      end
      default: begin
        q_next  = q;
        bit_out = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/universal_shift_register.sv
// Register with load/clear and N-step shift/rotate under a start/busy/done handshake.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] amount,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             shift_out,
  output logic             busy,
  output logic             done
);

  state_e           state, state_n;
  op_e              op_r, op_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] q_n;
  logic             so_n;
  logic             done_n;
  op_e              op_in;
  op_e              step_op;
  logic [WIDTH-1:0] step_q;
  logic             step_bit;

  assign op_in = op_e'(op);
  // The first step runs on the acceptance edge, so the step unit sees the live op while idle.
  assign step_op = (state == ST_SHIFT) ? op_r : op_in;

  usr_step #(.WIDTH(WIDTH)) u_step (
    .q      (q),
    .op     (step_op),
    .ser_in (ser_in),
    .q_next (step_q),
    .bit_out(step_bit)
  );

  always_comb begin
    state_n = state;
    op_n    = op_r;
    cnt_n   = cnt;
    q_n     = q;
    so_n    = shift_out;
    done_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          op_n = op_in;
          if (op_in == OP_LOAD) begin
            q_n    = d;
            done_n = 1'b1;
          end else if (op_in == OP_CLEAR) begin
            q_n    = '0;
            done_n = 1'b1;
          end else if (!is_shift_op(op_in) || amount == '0) begin
            done_n = 1'b1;
          end else begin
            q_n  = step_q;
            so_n = step_bit;
            if (amount == CNT_W'(1)) begin
              done_n = 1'b1;
            end else begin
              cnt_n   = amount - CNT_W'(1);
              state_n = ST_SHIFT;
            end
          end
        end
      end
      ST_SHIFT: begin
        q_n   = step_q;
        so_n  = step_bit;
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      op_r      <= OP_HOLD;
      cnt       <= '0;
      q         <= '0;
      shift_out <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      op_r      <= op_n;
      cnt       <= cnt_n;
      q         <= q_n;
      shift_out <= so_n;
      done      <= done_n;
    end
  end

  assign busy = (state == ST_SHIFT);

endmodule
